turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Controller for the tic-tac-toe board datapath. Turns raw player inputs (X/O buttons plus a 9-bit square select) into validated, one-cycle board write strobes. Sequences turns, samples the win checker after every write, and drives the turn LEDs, the ASCII game status and the move count. Sits between the button/switch inputs and the board register plus win-check logic.

## Interface
- FIRST_X, default 1, meaning 1 = X moves first after reset, 0 = O moves first.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low; clock clk.
- button_x  input  1  X player place request (level, synchronous to clk).
- button_o  input  1  O player place request (level, synchronous to clk).
- sel_pos  input  9  target square select; must be one-hot. Bit 8 = top-left, bit 0 = bottom-right.
- occ_square  input  9  board occupancy from the board register.
- win_result  input  2  win checker result: 0 none, 1 cats, 2 O wins, 3 X wins.
- wr_en  output  1  one-cycle board write strobe.
- wr_pos  output  9  square to write; a registered copy of sel_pos. Zero when wr_en=0.
- wr_player  output  1  1 = X, 0 = O; valid with wr_en.
- turn_x  output  1  high while X is to move (including ERR_X).
- turn_o  output  1  high while O is to move (including ERR_O).
- game_st  output  8  ASCII status: 8'h00 playing, 'X' 8'h58, 'O' 8'h4F, 'C' 8'h43, 'E' 8'h45.
- move_cnt  output  4  number of accepted moves, 0..9.

## Operation
- Request detection:
  - Each button is registered once (prev_x, prev_o).
  - A press is the rising edge: button & ~prev.
  - A held button produces exactly one press.
- Validity rules, evaluated on a press cycle. A press is valid only when all of the following hold:
  - exactly one of press_x/press_o is high;
  - the pressing player is the player to move;
  - sel_pos is one-hot (not zero, not multi-bit);
  - (sel_pos & occ_square) == 0.
- States: START, TURN_X, TURN_O, ERR_X, ERR_O, WRITE, CHECK, WIN_X, WIN_O, CATS.
- START:
  - The state immediately after reset deassertion.
  - Always goes to TURN_X if FIRST_X=1, else TURN_O.
- TURN_p / ERR_p (p = player to move):
  - No press: stay.
  - Valid press: latch sel_pos into wr_pos and p into wr_player, then go to WRITE.
  - Any invalid press: go to (or stay in) ERR_p.
  - The error clears only on a valid move by p.
- WRITE:
  - wr_en=1 for exactly this cycle.
  - move_cnt increments at the end of this cycle.
  - Always goes to CHECK.
- CHECK:
  - Sample win_result (the board is updated by now):
    - 3 → WIN_X.
    - 2 → WIN_O.
    - 1 → CATS.
    - 0 → TURN of the other player.
  - If win_result=0 and move_cnt==9: go to CATS (safety net; flags checker inconsistency).
- WIN_X, WIN_O, CATS: terminal. All presses are ignored; leave only via reset.
- Press edges arriving during WRITE or CHECK are discarded. They are not queued.
- Outputs are Moore, decoded from state:
  - game_st: 'E' in ERR_*, 'X'/'O'/'C' in terminal states, otherwise 8'h00.
  - turn_x/turn_o: both 0 in START, WRITE, CHECK and terminal states.

## Timing
- Reset (reset=0), asynchronous:
  - state=START, prev_x=prev_o=0, wr_en=0, wr_pos=0, wr_player=0, move_cnt=0.
  - turn_x=turn_o=0, game_st=8'h00.
- Reset asserted mid-game (including in WRITE) aborts immediately. No write strobe follows.
- First press-to-write latency:
  - A button rising at edge N is seen as a press in cycle N.
  - wr_en is high in cycle N+1.
  - game_st/turn outputs update at the start of cycle N+3 (after CHECK).
- Turn period: minimum 3 cycles per accepted move (TURN → WRITE → CHECK).
- Error entry: game_st='E' is visible 1 cycle after the invalid press.
- move_cnt saturates at 9 and never wraps.

## Structure
- Shared package game_pkg holds:
  - state encoding (4-bit);
  - WIN_ST_* codes (NONE=0, CATS=1, WINO=2, WINX=3);
  - ASCII constants GST_PLAY/GST_X/GST_O/GST_CATS/GST_ERR.
- Sub-module move_check: combinational validity from press_x, press_o, turn, sel_pos and occ_square. Outputs valid plus an err_cause[2:0] vector (two_buttons, wrong_turn, bad_sel) for debug.
- The FSM, edge registers and move counter stay in turn_sequencer.

## Test plan
- Reset, then X press at sel_pos=9'h010 with occ_square=0:
  - wr_en for one cycle with wr_pos=9'h010, wr_player=1.
  - win_result=0 in CHECK → turn_o=1, move_cnt=1.
- In TURN_O, press button_x at sel_pos=9'h001:
  - game_st=8'h45, turn_o stays 1, no wr_en.
  - Then a valid O press at 9'h001 → wr_en, game_st=8'h00.
- Occupied/bad select:
  - occ_square=9'h010, X presses at 9'h010 → 'E'.
  - sel_pos=9'h003 → 'E'.
  - Both buttons rising in the same cycle → 'E'.
- Win and terminal:
  - Drive win_result=3 during CHECK → game_st=8'h58, turn_x=turn_o=0.
  - Further presses → no wr_en.
  - reset=0 → all outputs return to reset values.
- Hold and cats:
  - Hold button_x high for 20 cycles → exactly one wr_en.
  - Play 9 valid moves with win_result=0 throughout → CATS ('C') after the 9th CHECK, move_cnt=9.
- Assert reset during WRITE → wr_en drops immediately, state=START, move_cnt=0.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the tic-tac-toe controller.
//               - Sequencer state encoding (4-bit).
//               - Win-checker result codes.
//               - ASCII game status codes.
//               - One-hot helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

   typedef enum logic [3:0] {
      START  = 4'd0,
      TURN_X = 4'd1,
      TURN_O = 4'd2,
      ERR_X  = 4'd3,
      ERR_O  = 4'd4,
      WRITE  = 4'd5,
      CHECK  = 4'd6,
      WIN_X  = 4'd7,
      WIN_O  = 4'd8,
      CATS   = 4'd9
   } state_t;

   localparam logic [1:0] WIN_ST_NONE = 2'd0;
   localparam logic [1:0] WIN_ST_CATS = 2'd1;
   localparam logic [1:0] WIN_ST_WINO = 2'd2;
   localparam logic [1:0] WIN_ST_WINX = 2'd3;

   localparam logic [7:0] GST_PLAY = 8'h00;
   localparam logic [7:0] GST_X    = 8'h58;
   localparam logic [7:0] GST_O    = 8'h4F;
   localparam logic [7:0] GST_CATS = 8'h43;
   localparam logic [7:0] GST_ERR  = 8'h45;

   localparam logic [3:0] MAX_MOVES = 4'd9;

   // Non-zero with a single bit set.
   function automatic logic is_onehot9(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/turn_sequencer_move_check.sv
`default_nettype none
// ============================================================================
// Module      : move_check
// Description : Combinational validity check for a place request.
// Ports       : press_x, press_o - rising-edge presses for this cycle
//               turn             - 1 = X to move, 0 = O to move
//               sel_pos[8:0]     - requested square (must be one-hot)
//               occ_square[8:0]  - current board occupancy
//               valid            - request may be written to the board
//               err_cause[2:0]   - {two_buttons, wrong_turn, bad_sel}
// Revision    : 1.0 - initial release
// ============================================================================
module move_check
   import game_pkg::*;
(
   input  logic       press_x,
   input  logic       press_o,
   input  logic       turn,
   input  logic [8:0] sel_pos,
   input  logic [8:0] occ_square,
   output logic       valid,
   output logic [2:0] err_cause
);

   logic w_any_press;
   logic w_one_press;
   logic w_two_buttons;
   logic w_wrong_turn;
   logic w_bad_sel;

   assign w_any_press   = press_x | press_o;
   assign w_one_press   = press_x ^ press_o;
   assign w_two_buttons = press_x & press_o;
   // Only meaningful for a single press; a double press is already flagged.
   assign w_wrong_turn  = w_one_press & (press_x != turn);
   // Covers zero, multi-bit and already-occupied selections.
   assign w_bad_sel     = w_any_press &
                          (!is_onehot9(sel_pos) || ((sel_pos & occ_square) != 9'd0));

   assign valid     = w_one_press & ~w_wrong_turn & ~w_bad_sel;
   assign err_cause = {w_two_buttons, w_wrong_turn, w_bad_sel};

endmodule
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : turn_sequencer
// Description : Turn sequencer for the tic-tac-toe board datapath. Converts
//               button presses into validated one-cycle board writes, checks
//               the win result after each write and drives status outputs.
// Ports       : clk, reset (async, active-low)
//               button_x, button_o  - player place requests (levels)
//               sel_pos[8:0]        - target square, one-hot
//               occ_square[8:0]     - board occupancy
//               win_result[1:0]     - win checker result
//               wr_en, wr_pos[8:0], wr_player - board write strobe
//               turn_x, turn_o      - player-to-move LEDs
//               game_st[7:0]        - ASCII status
//               move_cnt[3:0]       - accepted moves, 0..9
// Revision    : 1.0 - initial release
// ============================================================================
module turn_sequencer
   import game_pkg::*;
#(
   parameter bit FIRST_X = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button_x,
   input  logic       button_o,
   input  logic [8:0] sel_pos,
   input  logic [8:0] occ_square,
   input  logic [1:0] win_result,
   output logic       wr_en,
   output logic [8:0] wr_pos,
   output logic       wr_player,
   output logic       turn_x,
   output logic       turn_o,
   output logic [7:0] game_st,
   output logic [3:0] move_cnt
);

   state_t     r_state;
   state_t     w_next;
   logic       r_prev_x;
   logic       r_prev_o;
   logic [8:0] r_wr_pos;
   logic       r_wr_player;
   logic [3:0] r_move_cnt;

   logic       w_press_x;
   logic       w_press_o;
   logic       w_turn_is_x;
   logic       w_valid;
   logic [2:0] w_err_cause;
   logic       w_latch;

   assign w_press_x   = button_x & ~r_prev_x;
   assign w_press_o   = button_o & ~r_prev_o;
   assign w_turn_is_x = (r_state == TURN_X) || (r_state == ERR_X);

   move_check u_move_check (
      .press_x    (w_press_x),
      .press_o    (w_press_o),
      .turn       (w_turn_is_x),
      .sel_pos    (sel_pos),
      .occ_square (occ_square),
      .valid      (w_valid),
      .err_cause  (w_err_cause)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= START;
         r_prev_x    <= 1'b0;
         r_prev_o    <= 1'b0;
         r_wr_pos    <= 9'd0;
         r_wr_player <= 1'b0;
         r_move_cnt  <= 4'd0;
      end else begin
         r_state  <= w_next;
         // Edge registers run every cycle, so edges during WRITE/CHECK are lost.
         r_prev_x <= button_x;
         r_prev_o <= button_o;
         if (w_latch) begin
            r_wr_pos    <= sel_pos;
            r_wr_player <= w_turn_is_x;
         end
         if ((r_state == WRITE) && (r_move_cnt != MAX_MOVES)) begin
            r_move_cnt <= r_move_cnt + 4'd1;
         end
      end
   end

   always_comb begin
      w_next  = r_state;
      w_latch = 1'b0;
      wr_en   = 1'b0;
      turn_x  = 1'b0;
      turn_o  = 1'b0;
      game_st = GST_PLAY;
      case (r_state)
         START: begin
            w_next = FIRST_X ? TURN_X : TURN_O;
         end
         TURN_X, ERR_X, TURN_O, ERR_O: begin
            turn_x = w_turn_is_x;
            turn_o = ~w_turn_is_x;
            if ((r_state == ERR_X) || (r_state == ERR_O)) begin
               game_st = GST_ERR;
            end
            if (w_valid) begin
               w_next  = WRITE;
               w_latch = 1'b1;
            end else if (w_err_cause != 3'd0) begin
               w_next = w_turn_is_x ? ERR_X : ERR_O;
            end
         end
         WRITE: begin
            wr_en  = 1'b1;
            w_next = CHECK;
         end
         CHECK: begin
            case (win_result)
               WIN_ST_WINX: w_next = WIN_X;
               WIN_ST_WINO: w_next = WIN_O;
               WIN_ST_CATS: w_next = CATS;
               default: begin
                  // A full board with no result means the checker missed it.
                  if (r_move_cnt == MAX_MOVES) begin
                     w_next = CATS;
                  end else begin
                     w_next = r_wr_player ? TURN_O : TURN_X;
                  end
               end
            endcase
         end
         WIN_X:   game_st = GST_X;
         WIN_O:   game_st = GST_O;
         CATS:    game_st = GST_CATS;
         default: w_next  = START;
      endcase
   end

   assign wr_pos    = wr_en ? r_wr_pos : 9'd0;
   assign wr_player = r_wr_player;
   assign move_cnt  = r_move_cnt;

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_sequencer
// Description : Self-checking bench for turn_sequencer. A game-level model
//               (player to move, board, move count, error/over flags) predicts
//               the outcome of every press.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       button_x = 1'b0;
   logic       button_o = 1'b0;
   logic [8:0] sel_pos = 9'd0;
   logic [8:0] occ_square = 9'd0;
   logic [1:0] win_result = 2'd0;
   logic       wr_en;
   logic [8:0] wr_pos;
   logic       wr_player;
   logic       turn_x;
   logic       turn_o;
   logic [7:0] game_st;
   logic [3:0] move_cnt;

   int n_chk = 0;
   int n_err = 0;

   // Game-level model
   logic       m_x_turn;
   logic [3:0] m_cnt;
   logic       m_err;
   logic       m_over;
   logic [7:0] m_gst;

   always #5 clk = ~clk;

   turn_sequencer #(.FIRST_X(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .button_x   (button_x),
      .button_o   (button_o),
      .sel_pos    (sel_pos),
      .occ_square (occ_square),
      .win_result (win_result),
      .wr_en      (wr_en),
      .wr_pos     (wr_pos),
      .wr_player  (wr_player),
      .turn_x     (turn_x),
      .turn_o     (turn_o),
      .game_st    (game_st),
      .move_cnt   (move_cnt)
   );

   function automatic logic [7:0] exp_gst();
      if (m_over) return m_gst;
      if (m_err)  return 8'h45;
      return 8'h00;
   endfunction

   function automatic logic [8:0] pick_empty(input logic [8:0] occ);
      int idx[$];
      for (int k = 0; k < 9; k++) if (!occ[k]) idx.push_back(k);
      if (idx.size() == 0) return 9'd0;
      return 9'd1 << idx[$urandom_range(0, idx.size() - 1)];
   endfunction

   function automatic logic [8:0] pick_taken(input logic [8:0] occ);
      int idx[$];
      for (int k = 0; k < 9; k++) if (occ[k]) idx.push_back(k);
      if (idx.size() == 0) return 9'd0;
      return 9'd1 << idx[$urandom_range(0, idx.size() - 1)];
   endfunction

   task automatic do_reset();
      reset = 1'b0; button_x = 1'b0; button_o = 1'b0;
      sel_pos = 9'd0; occ_square = 9'd0; win_result = 2'd0;
      m_x_turn = 1'b1; m_cnt = 4'd0; m_err = 1'b0; m_over = 1'b0; m_gst = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // One press attempt; the model decides what must happen.
   task automatic do_move(input logic bx, input logic bo,
                          input logic [8:0] sel, input logic [1:0] win);
      logic valid;
      valid = !m_over && (bx ^ bo) && (bx == m_x_turn) &&
              ($countones(sel) == 1) && ((sel & occ_square) == 9'd0);
      button_x = bx; button_o = bo; sel_pos = sel;
      @(negedge clk);
      n_chk++;
      if (valid) begin
         if ({wr_en, wr_pos, wr_player} !== {1'b1, sel, m_x_turn}) begin
            n_err++;
            $display("FAIL write_strobe: got en=%b pos=%h pl=%b, want en=1 pos=%h pl=%b",
                     wr_en, wr_pos, wr_player, sel, m_x_turn);
         end
         button_x = 1'b0; button_o = 1'b0; win_result = win;
         occ_square = occ_square | sel;
         @(negedge clk);
         n_chk++;
         if ({wr_en, wr_pos, turn_x, turn_o, move_cnt} !== {1'b0, 9'd0, 2'b00, m_cnt + 4'd1}) begin
            n_err++;
            $display("FAIL check_phase: got en=%b pos=%h tx=%b to=%b cnt=%0d, want 0 0 0 0 %0d",
                     wr_en, wr_pos, turn_x, turn_o, move_cnt, m_cnt + 4'd1);
         end
         m_cnt = m_cnt + 4'd1;
         m_err = 1'b0;
         case (win)
            2'd3: begin m_over = 1'b1; m_gst = 8'h58; end
            2'd2: begin m_over = 1'b1; m_gst = 8'h4F; end
            2'd1: begin m_over = 1'b1; m_gst = 8'h43; end
            default: begin
               if (m_cnt == 4'd9) begin m_over = 1'b1; m_gst = 8'h43; end
               else m_x_turn = ~m_x_turn;
            end
         endcase
         @(negedge clk);
         win_result = 2'd0;
      end else begin
         if (!m_over && (bx | bo)) m_err = 1'b1;
         if ({wr_en, game_st} !== {1'b0, exp_gst()}) begin
            n_err++;
            $display("FAIL reject_press: got en=%b st=%h, want en=0 st=%h",
                     wr_en, game_st, exp_gst());
         end
         button_x = 1'b0; button_o = 1'b0;
         @(negedge clk);
      end
      n_chk++;
      if ({wr_en, turn_x, turn_o, game_st, move_cnt} !==
          {1'b0, !m_over && m_x_turn, !m_over && !m_x_turn, exp_gst(), m_cnt}) begin
         n_err++;
         $display("FAIL settle: got en=%b tx=%b to=%b st=%h cnt=%0d, want 0 %b %b %h %0d",
                  wr_en, turn_x, turn_o, game_st, move_cnt,
                  !m_over && m_x_turn, !m_over && !m_x_turn, exp_gst(), m_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      n_chk++;
      if ({wr_en, wr_pos, wr_player, turn_x, turn_o, game_st, move_cnt} !== 25'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got en=%b pos=%h pl=%b tx=%b to=%b st=%h cnt=%0d, want all 0",
                  wr_en, wr_pos, wr_player, turn_x, turn_o, game_st, move_cnt);
      end
      do_reset();
      n_chk++;
      if ({turn_x, turn_o, game_st} !== {2'b10, 8'h00}) begin
         n_err++;
         $display("FAIL first_turn: got tx=%b to=%b st=%h, want 1 0 00", turn_x, turn_o, game_st);
      end
   endtask

   task automatic test_first_move();
      do_move(1'b1, 1'b0, 9'h010, 2'd0);
   endtask

   task automatic test_errors();
      do_move(1'b1, 1'b0, 9'h001, 2'd0);   // X presses on O's turn
      do_move(1'b0, 1'b1, 9'h001, 2'd0);   // O recovers
      do_move(1'b1, 1'b0, 9'h010, 2'd0);   // occupied
      do_move(1'b1, 1'b0, 9'h003, 2'd0);   // multi-bit
      do_move(1'b1, 1'b0, 9'h000, 2'd0);   // empty select
      do_move(1'b1, 1'b1, 9'h100, 2'd0);   // both buttons
      do_move(1'b1, 1'b0, 9'h100, 2'd0);   // X recovers
   endtask

   task automatic test_win();
      do_reset();
      do_move(1'b1, 1'b0, 9'h100, 2'd0);
      do_move(1'b0, 1'b1, 9'h010, 2'd0);
      do_move(1'b1, 1'b0, 9'h080, 2'd3);
      do_move(1'b0, 1'b1, 9'h001, 2'd0);   // ignored when over
      do_move(1'b1, 1'b0, 9'h002, 2'd0);
      reset = 1'b0;
      #1;
      n_chk++;
      if ({wr_en, wr_pos, wr_player, turn_x, turn_o, game_st, move_cnt} !== 25'd0) begin
         n_err++;
         $display("FAIL reset_after_win: got en=%b pos=%h pl=%b tx=%b to=%b st=%h cnt=%0d, want all 0",
                  wr_en, wr_pos, wr_player, turn_x, turn_o, game_st, move_cnt);
      end
   endtask

   task automatic test_hold();
      int strobes;
      do_reset();
      strobes = 0;
      button_x = 1'b1; sel_pos = 9'h100;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wr_en) strobes++;
      end
      button_x = 1'b0;
      @(negedge clk);
      m_cnt = 4'd1; m_x_turn = 1'b0; occ_square = 9'h100;
      n_chk++;
      if ({strobes[7:0], move_cnt, turn_o} !== {8'd1, 4'd1, 1'b1}) begin
         n_err++;
         $display("FAIL hold_single: got strobes=%0d cnt=%0d to=%b, want 1 1 1",
                  strobes, move_cnt, turn_o);
      end
   endtask

   task automatic test_cats();
      do_reset();
      for (int k = 0; k < 9; k++)
         do_move(m_x_turn, ~m_x_turn, pick_empty(occ_square), 2'd0);
      n_chk++;
      if ({game_st, move_cnt} !== {8'h43, 4'd9}) begin
         n_err++;
         $display("FAIL cats_full: got st=%h cnt=%0d, want 43 9", game_st, move_cnt);
      end
      do_move(1'b1, 1'b0, 9'h001, 2'd0);
   endtask

   task automatic test_random();
      do_reset();
      for (int it = 0; it < 60; it++) begin
         logic bx, bo;
         logic [8:0] sel;
         logic [1:0] win;
         int r;
         r = $urandom_range(0, 5);
         if (r < 4)       begin bx = m_x_turn;  bo = ~m_x_turn; end
         else if (r == 4) begin bx = ~m_x_turn; bo = m_x_turn;  end
         else             begin bx = 1'b1;      bo = 1'b1;      end
         r = $urandom_range(0, 6);
         if (r < 4)       sel = pick_empty(occ_square);
         else if (r == 4) sel = (occ_square != 9'd0) ? pick_taken(occ_square) : pick_empty(occ_square);
         else if (r == 5) sel = 9'h003 << $urandom_range(0, 7);
         else             sel = 9'd0;
         win = ($urandom_range(0, 9) < 8) ? 2'd0 : 2'($urandom_range(1, 3));
         do_move(bx, bo, sel, win);
         if (m_over) begin
            do_move(1'b1, 1'b0, pick_empty(occ_square), 2'd0);
            do_reset();
         end
      end
   endtask

   task automatic test_reset_in_write();
      do_reset();
      do_move(1'b1, 1'b0, 9'h001, 2'd0);
      button_o = 1'b1; sel_pos = 9'h002;
      @(negedge clk);
      n_chk++;
      if (wr_en !== 1'b1) begin
         n_err++;
         $display("FAIL write_before_abort: got en=%b, want 1", wr_en);
      end
      #2 reset = 1'b0;
      #1;
      n_chk++;
      if ({wr_en, wr_pos, turn_x, turn_o, game_st, move_cnt} !== 24'd0) begin
         n_err++;
         $display("FAIL abort_in_write: got en=%b pos=%h tx=%b to=%b st=%h cnt=%0d, want all 0",
                  wr_en, wr_pos, turn_x, turn_o, game_st, move_cnt);
      end
      button_o = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({wr_en, turn_x, move_cnt} !== 6'd0) begin
         n_err++;
         $display("FAIL abort_held: got en=%b tx=%b cnt=%0d, want 0 0 0", wr_en, turn_x, move_cnt);
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if ({turn_x, turn_o} !== 2'b00) begin
         n_err++;
         $display("FAIL start_state: got tx=%b to=%b, want 0 0", turn_x, turn_o);
      end
      @(negedge clk);
      n_chk++;
      if ({turn_x, turn_o, wr_en, move_cnt} !== {2'b10, 1'b0, 4'd0}) begin
         n_err++;
         $display("FAIL restart_turn: got tx=%b to=%b en=%b cnt=%0d, want 1 0 0 0",
                  turn_x, turn_o, wr_en, move_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_first_move();
      test_errors();
      test_win();
      test_hold();
      test_cats();
      test_random();
      test_reset_in_write();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
